fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding/hazard unit for the N-stage pipelined core (successor to the 2-stage inline busy1/busy2 logic).

---
 rtl/core_pipe_pkg.sv | 8 +
 rtl/fwd_match_cell.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 105 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_pkg.sv
// Shared pipeline definitions for the forwarding/hazard logic.
// Defines the regfile select code and the default register-index width.
package core_pipe_pkg;

  localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
  localparam int FWD_SEL_REGFILE         = 0;

endpackage

// File: rtl/fwd_match_cell.sv
// Compares one scoreboard entry against one decode operand.
// load_hit flags a match on a load that is still too young to forward.
module fwd_match_cell #(
  parameter int RIW                = 4,
  parameter bit ZERO_REG_HARDWIRED = 1'b0,
  parameter bit IN_LOAD_WINDOW     = 1'b0
) (
  input  logic           valid,
  input  logic           wrt_en,
  input  logic [RIW-1:0] dr,
  input  logic           is_load,
  input  logic [RIW-1:0] src_ind,
  input  logic           src_used,
  output logic           match,
  output logic           load_hit
);

  logic zero_block;

  // A hardwired r0 never produces a dependence, whatever is in flight.
  assign zero_block = ZERO_REG_HARDWIRED && (src_ind == '0);
  assign match      = valid & wrt_en & src_used & (dr == src_ind) & ~zero_block;
  assign load_hit   = match & is_load & IN_LOAD_WINDOW;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Scoreboard of in-flight destinations past EX: picks the youngest forwarding
// source per decode operand and stalls decode on load-use dependences.
module fwd_hazard_unit
  import core_pipe_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
  parameter int STAGES              = 2,
  parameter int LOAD_LAT            = 1,
  parameter int ZERO_REG_HARDWIRED  = 0,
  parameter int SEL_W               = $clog2(STAGES + 1),
  parameter int CNT_W               = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_ind,
  input  logic                           src1_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src2_ind,
  input  logic                           src2_used,
  input  logic                           issue_valid,
  input  logic                           issue_wrt_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] issue_dr,
  input  logic                           issue_is_load,
  input  logic                           flush,
  output logic [SEL_W-1:0]               fwd_sel1,
  output logic [SEL_W-1:0]               fwd_sel2,
  output logic                           stall,
  output logic [CNT_W-1:0]               stall_cnt
);

  typedef struct packed {
    logic                           valid;
    logic                           wrt_en;
    logic [REG_INDEX_BIT_WIDTH-1:0] dr;
    logic                           is_load;
  } entry_t;

  entry_t            sb [STAGES];
  logic [STAGES-1:0] match1, match2, hit1, hit2;
  logic              haz1, haz2;

  for (genvar k = 0; k < STAGES; k++) begin : g_cell
    fwd_match_cell #(
      .RIW               (REG_INDEX_BIT_WIDTH),
      .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED != 0),
      .IN_LOAD_WINDOW    (k < LOAD_LAT)
    ) u_op1 (
      .valid(sb[k].valid), .wrt_en(sb[k].wrt_en), .dr(sb[k].dr), .is_load(sb[k].is_load),
      .src_ind(src1_ind), .src_used(src1_used), .match(match1[k]), .load_hit(hit1[k])
    );
    fwd_match_cell #(
      .RIW               (REG_INDEX_BIT_WIDTH),
      .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED != 0),
      .IN_LOAD_WINDOW    (k < LOAD_LAT)
    ) u_op2 (
      .valid(sb[k].valid), .wrt_en(sb[k].wrt_en), .dr(sb[k].dr), .is_load(sb[k].is_load),
      .src_ind(src2_ind), .src_used(src2_used), .match(match2[k]), .load_hit(hit2[k])
    );
  end

  // Scan oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    fwd_sel1 = SEL_W'(FWD_SEL_REGFILE);
    haz1     = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (match1[j]) begin
        fwd_sel1 = SEL_W'(j + 1);
        haz1     = hit1[j];
      end
    end
  end

  always_comb begin
    fwd_sel2 = SEL_W'(FWD_SEL_REGFILE);
    haz2     = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (match2[j]) begin
        fwd_sel2 = SEL_W'(j + 1);
        haz2     = hit2[j];
      end
    end
  end

  assign stall = (haz1 | haz2) & ~flush;

  // Stalled or flushed decode slots enter the pipe as bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) sb[i] <= '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--) sb[i] <= sb[i-1];
      if (issue_valid && !stall && !flush)
        sb[0] <= '{1'b1, issue_wrt_en, issue_dr, issue_is_load};
      else
        sb[0] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a cycle-by-cycle vector table plus
// hand sequences for reset, mid-stall reset and counter saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src1_ind = '0, src2_ind = '0, issue_dr = '0;
  logic       src1_used = 1'b0, src2_used = 1'b0;
  logic       issue_valid = 1'b0, issue_wrt_en = 1'b0, issue_is_load = 1'b0, flush = 1'b0;

  logic [1:0]  sel1_a, sel2_a, sel1_z, sel2_z, sel1_c, sel2_c;
  logic        stall_a, stall_z, stall_c;
  logic [31:0] cnt_a, cnt_z;
  logic [3:0]  cnt_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .src1_ind(src1_ind), .src1_used(src1_used),
    .src2_ind(src2_ind), .src2_used(src2_used), .issue_valid(issue_valid),
    .issue_wrt_en(issue_wrt_en), .issue_dr(issue_dr), .issue_is_load(issue_is_load),
    .flush(flush), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall(stall_a), .stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(.ZERO_REG_HARDWIRED(1)) dut_zero (
    .clk(clk), .reset(reset), .src1_ind(src1_ind), .src1_used(src1_used),
    .src2_ind(src2_ind), .src2_used(src2_used), .issue_valid(issue_valid),
    .issue_wrt_en(issue_wrt_en), .issue_dr(issue_dr), .issue_is_load(issue_is_load),
    .flush(flush), .fwd_sel1(sel1_z), .fwd_sel2(sel2_z), .stall(stall_z), .stall_cnt(cnt_z)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_cnt (
    .clk(clk), .reset(reset), .src1_ind(src1_ind), .src1_used(src1_used),
    .src2_ind(src2_ind), .src2_used(src2_used), .issue_valid(issue_valid),
    .issue_wrt_en(issue_wrt_en), .issue_dr(issue_dr), .issue_is_load(issue_is_load),
    .flush(flush), .fwd_sel1(sel1_c), .fwd_sel2(sel2_c), .stall(stall_c), .stall_cnt(cnt_c)
  );

  typedef struct {
    string name;
    int s1, u1, s2, u2, iv, we, dr, ld, fl;
    int e_sel1, e_sel2, e_stall, e_cnt, z_sel1, z_stall;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(string name, int s1, int u1, int s2, int u2, int iv, int we,
                              int dr, int ld, int fl, int e_sel1, int e_sel2, int e_stall,
                              int e_cnt, int z_sel1, int z_stall);
    vec_t v;
    v.name = name; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2; v.iv = iv; v.we = we;
    v.dr = dr; v.ld = ld; v.fl = fl; v.e_sel1 = e_sel1; v.e_sel2 = e_sel2;
    v.e_stall = e_stall; v.e_cnt = e_cnt; v.z_sel1 = z_sel1; v.z_stall = z_stall;
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input int s1, input int u1, input int s2, input int u2, input int iv,
                       input int we, input int dr, input int ld, input int fl);
    src1_ind = 4'(s1); src1_used = u1[0]; src2_ind = 4'(s2); src2_used = u2[0];
    issue_valid = iv[0]; issue_wrt_en = we[0]; issue_dr = 4'(dr);
    issue_is_load = ld[0]; flush = fl[0];
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    drive(v.s1, v.u1, v.s2, v.u2, v.iv, v.we, v.dr, v.ld, v.fl);
    #2;
    check_output({v.name, ".sel1"}, int'(sel1_a), v.e_sel1);
    check_output({v.name, ".sel2"}, int'(sel2_a), v.e_sel2);
    check_output({v.name, ".stall"}, int'(stall_a), v.e_stall);
    check_output({v.name, ".cnt"}, int'(cnt_a), v.e_cnt);
    check_output({v.name, ".zsel1"}, int'(sel1_z), v.z_sel1);
    check_output({v.name, ".zstall"}, int'(stall_z), v.z_stall);
  endtask

  task automatic step(input int s1, input int u1, input int s2, input int u2, input int iv,
                      input int we, input int dr, input int ld, input int fl);
    @(posedge clk);
    #1;
    drive(s1, u1, s2, u2, iv, we, dr, ld, fl);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk("idle",          0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[1]  = mk("issue_r3",      0,0,0,0, 1,1,3,0,0, 0,0,0,0, 0,0);
    tbl[2]  = mk("fwd_e0",        3,1,0,0, 0,0,0,0,0, 1,0,0,0, 1,0);
    tbl[3]  = mk("fwd_e1",        3,1,0,0, 0,0,0,0,0, 2,0,0,0, 2,0);
    tbl[4]  = mk("retired",       3,1,0,0, 0,0,0,0,0, 0,0,0,0, 0,0);
    tbl[5]  = mk("issue_r5",      0,0,0,0, 1,1,5,0,0, 0,0,0,0, 0,0);
    tbl[6]  = mk("r5_again",      5,1,5,1, 1,1,5,0,0, 1,1,0,0, 1,0);
    tbl[7]  = mk("youngest",      5,1,5,1, 0,0,0,0,0, 1,1,0,0, 1,0);
    tbl[8]  = mk("r5_e1",         5,1,0,0, 0,0,0,0,0, 2,0,0,0, 2,0);
    tbl[9]  = mk("issue_lw_r4",   0,0,0,0, 1,1,4,1,0, 0,0,0,0, 0,0);
    tbl[10] = mk("load_use",      0,0,4,1, 1,1,6,0,0, 0,1,1,0, 0,1);
    tbl[11] = mk("load_resolved", 0,0,4,1, 1,1,6,0,0, 0,2,0,1, 0,0);
    tbl[12] = mk("r6_fwd",        6,1,4,1, 0,0,0,0,0, 1,0,0,1, 1,0);
    tbl[13] = mk("issue_lw_r4b",  0,0,0,0, 1,1,4,1,0, 0,0,0,1, 0,0);
    tbl[14] = mk("flush_wins",    0,0,4,1, 1,1,7,0,1, 0,1,0,1, 0,0);
    tbl[15] = mk("after_flush",   7,1,4,1, 0,0,0,0,0, 0,2,0,1, 0,0);
    tbl[16] = mk("issue_r8",      0,0,0,0, 1,1,8,0,0, 0,0,0,1, 0,0);
    tbl[17] = mk("unused_src",    8,0,8,1, 1,0,9,0,0, 0,1,0,1, 0,0);
    tbl[18] = mk("no_write",      9,1,8,1, 0,0,0,0,0, 0,2,0,1, 0,0);
    tbl[19] = mk("issue_lw_r0",   0,0,0,0, 1,1,0,1,0, 0,0,0,1, 0,0);
    tbl[20] = mk("r0_load_use",   0,1,0,0, 0,0,0,0,0, 1,0,1,1, 0,0);
    tbl[21] = mk("r0_resolved",   0,1,0,0, 0,0,0,0,0, 2,0,0,2, 0,0);

    // Reset asserted with garbage on the inputs: outputs must stay quiet.
    #1 reset = 1'b0;
    #2;
    check_output("reset_async.sel1", int'(sel1_a), 0);
    check_output("reset_async.stall", int'(stall_a), 0);
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1), 0);
      check_output($sformatf("reset_hold%0d.sel1", i), int'(sel1_a), 0);
      check_output($sformatf("reset_hold%0d.sel2", i), int'(sel2_a), 0);
      check_output($sformatf("reset_hold%0d.stall", i), int'(stall_a), 0);
      check_output($sformatf("reset_hold%0d.cnt", i), int'(cnt_a), 0);
    end
    step(0,0,0,0, 0,0,0,0,0);
    reset = 1'b1;
    step(0,0,0,0, 0,0,0,0,0);
    step(3,1,5,1, 0,0,0,0,0);
    check_output("post_reset.sel1", int'(sel1_a), 0);
    check_output("post_reset.sel2", int'(sel2_a), 0);
    check_output("post_reset.stall", int'(stall_a), 0);

    for (int i = 0; i < 22; i++) apply_stimulus(tbl[i]);

    // Reset dropped in the middle of a load-use stall.
    step(0,0,0,0, 1,1,2,1,0);
    step(2,1,0,0, 0,0,0,0,0);
    check_output("midstall.stall_before", int'(stall_a), 1);
    #1 reset = 1'b0;
    #1;
    check_output("midstall.stall_async", int'(stall_a), 0);
    check_output("midstall.sel1_async", int'(sel1_a), 0);
    check_output("midstall.cnt_async", int'(cnt_a), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check_output("midstall.no_phantom_sel1", int'(sel1_a), 0);
    check_output("midstall.no_phantom_stall", int'(stall_a), 0);

    // Twenty separate load-use stalls: 32-bit counter reaches 20, 4-bit one pins at 15.
    for (int i = 0; i < 20; i++) begin
      step(0,0,0,0, 1,1,1,1,0);
      step(1,1,0,0, 0,0,0,0,0);
      if (i == 0) check_output("sat.first_stall", int'(stall_c), 1);
      if (i == 15) check_output("sat.cnt_at_15", int'(cnt_c), 15);
    end
    step(0,0,0,0, 0,0,0,0,0);
    check_output("sat.cnt32", int'(cnt_a), 20);
    check_output("sat.cnt4", int'(cnt_c), 15);
    check_output("sat.stall_idle", int'(stall_c), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
